// File: rtl/program_launcher_if.sv
//------------------------------------------------------------------------------
// program_launcher_if : Go/Done handshake and launcher status bus
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_launcher_if #(
   parameter int unsigned CW = 16
);
   logic          Go;
   logic          Done;
   logic          Start;
   logic [1:0]    ProgIdx;
   logic          Busy;
   logic          Finished;
   logic          TimedOut;
   logic [CW-1:0] LastCycles;

   modport master (
      output Go, Done,
      input  Start, ProgIdx, Busy, Finished, TimedOut, LastCycles
   );

   modport slave (
      input  Go, Done,
      output Start, ProgIdx, Busy, Finished, TimedOut, LastCycles
   );
endinterface

`default_nettype wire

// File: rtl/program_launcher.sv
//------------------------------------------------------------------------------
// program_launcher : launches up to NPROG programs, times each, aborts on timeout
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_launcher #(
   parameter int unsigned NPROG    = 3,
   parameter int unsigned START_HI = 2,
   parameter int unsigned CW       = 16,
   parameter int unsigned TIMEOUT  = 16'hFFFF
) (
   input  wire logic         Clk,
   input  wire logic         Reset,
   program_launcher_if.slave bus
);

   localparam int unsigned c_pw = (START_HI > 1) ? $clog2(START_HI) : 1;
   localparam logic [c_pw-1:0] c_pulse_last = c_pw'(START_HI - 1);
   localparam logic [CW-1:0]   c_tmo        = CW'(TIMEOUT);
   localparam logic [CW-1:0]   c_tmo_last   = CW'(TIMEOUT - 1);
   localparam logic [1:0]      c_last_idx   = 2'(NPROG);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PULSE  = 2'd1,
      S_RUN    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t          state_q;
   logic            start_q;
   logic [1:0]      idx_q;
   logic            busy_q;
   logic            fin_q;
   logic            to_q;
   logic [CW-1:0]   last_q;
   logic [c_pw-1:0] pcnt_q;
   logic [CW-1:0]   cnt_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         idx_q   <= 2'd0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         to_q    <= 1'b0;
         last_q  <= '0;
         pcnt_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.Go) begin
                  state_q <= S_PULSE;
                  start_q <= 1'b1;
                  idx_q   <= 2'd1;
                  busy_q  <= 1'b1;
                  pcnt_q  <= '0;
               end
            end
            // Done is deliberately not looked at here: it may still be high from the previous program
            S_PULSE: begin
               if (pcnt_q == c_pulse_last) begin
                  state_q <= S_RUN;
                  start_q <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  pcnt_q <= pcnt_q + 1'b1;
               end
            end
            S_RUN: begin
               if (bus.Done) begin
                  last_q <= cnt_q;
                  if (idx_q == c_last_idx) begin
                     state_q <= S_FINISH;
                     busy_q  <= 1'b0;
                     fin_q   <= 1'b1;
                  end else begin
                     state_q <= S_PULSE;
                     idx_q   <= idx_q + 2'd1;
                     start_q <= 1'b1;
                     pcnt_q  <= '0;
                  end
               end else if (cnt_q == c_tmo_last) begin
                  state_q <= S_FINISH;
                  busy_q  <= 1'b0;
                  fin_q   <= 1'b1;
                  to_q    <= 1'b1;
                  last_q  <= c_tmo;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FINISH: begin
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Start      = start_q;
   assign bus.ProgIdx    = idx_q;
   assign bus.Busy       = busy_q;
   assign bus.Finished   = fin_q;
   assign bus.TimedOut   = to_q;
   assign bus.LastCycles = last_q;

endmodule

`default_nettype wire

// File: tb/tb_program_launcher.sv
//------------------------------------------------------------------------------
// tb_program_launcher : schedule-based reference model with directed and random sequences
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_launcher;

   localparam int unsigned NPROG = 3;
   localparam int unsigned SH    = 2;
   localparam int unsigned CW    = 16;
   localparam int unsigned T     = 20;
   localparam int          N     = 256;

   logic Clk;
   logic Reset;

   program_launcher_if #(.CW(CW)) bus();

   program_launcher #(
      .NPROG   (NPROG),
      .START_HI(SH),
      .CW      (CW),
      .TIMEOUT (T)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Expected outputs after each posedge, and inputs presented to each posedge
   int e_start[N];
   int e_idx[N];
   int e_busy[N];
   int e_fin[N];
   int e_to[N];
   int e_last[N];
   bit v_go[N];
   bit v_done[N];

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_from(input int c0, input int st, input int ix, input int bz,
                           input int fn, input int tm, input int ls);
      for (int c = c0; c < N; c++) begin
         e_start[c] = st;
         e_idx[c]   = ix;
         e_busy[c]  = bz;
         e_fin[c]   = fn;
         e_to[c]    = tm;
         e_last[c]  = ls;
      end
   endtask

   // d[k] is the RUN-cycle count at which program k+1 reports Done; d>=T means never
   task automatic plan(input int go_cyc, input int d[3], input int noise, input bit hold);
      int e;
      int lc;
      e  = go_cyc;
      lc = 0;
      for (int c = 0; c < N; c++) begin
         v_go[c]   = (c == go_cyc) || (c > go_cyc && (hold || ($urandom_range(0, 1) == 1)));
         v_done[c] = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      set_from(0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= int'(NPROG); k++) begin
         set_from(e, 1, k, 1, 0, 0, lc);
         set_from(e + int'(SH), 0, k, 1, 0, 0, lc);
         if (d[k-1] < int'(T)) begin
            for (int j = 0; j < d[k-1]; j++) v_done[e + int'(SH) + 1 + j] = 1'b0;
            v_done[e + int'(SH) + 1 + d[k-1]] = 1'b1;
            lc = d[k-1];
            if (k == int'(NPROG)) begin
               set_from(e + int'(SH) + 1 + d[k-1], 0, k, 0, 1, 0, lc);
               break;
            end
            e = e + int'(SH) + 1 + d[k-1];
         end else begin
            for (int j = 0; j < int'(T); j++) v_done[e + int'(SH) + 1 + j] = 1'b0;
            set_from(e + int'(SH) + int'(T), 0, k, 0, 1, 1, int'(T));
            break;
         end
      end
   endtask

   task automatic chk_reset(input string tag, input int cyc);
      chk({tag, "_start"}, cyc, 32'(bus.Start), 0);
      chk({tag, "_idx"},   cyc, 32'(bus.ProgIdx), 0);
      chk({tag, "_busy"},  cyc, 32'(bus.Busy), 0);
      chk({tag, "_fin"},   cyc, 32'(bus.Finished), 0);
      chk({tag, "_to"},    cyc, 32'(bus.TimedOut), 0);
      chk({tag, "_last"},  cyc, 32'(bus.LastCycles), 0);
   endtask

   task automatic run(input int go_cyc, input int d[3], input int noise, input bit hold,
                      input int ncyc, input int abort_edge);
      plan(go_cyc, d, noise, hold);
      @(negedge Clk);
      Reset    = 1'b0;
      bus.Go   = 1'b0;
      bus.Done = 1'b0;
      #1;
      chk_reset("rst", -1);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk_reset("release", -1);
      for (int c = 0; c < ncyc; c++) begin
         bus.Go   = v_go[c];
         bus.Done = v_done[c];
         @(posedge Clk);
         @(negedge Clk);
         chk("start", c, 32'(bus.Start),      32'(e_start[c]));
         chk("idx",   c, 32'(bus.ProgIdx),    32'(e_idx[c]));
         chk("busy",  c, 32'(bus.Busy),       32'(e_busy[c]));
         chk("fin",   c, 32'(bus.Finished),   32'(e_fin[c]));
         chk("tmo",   c, 32'(bus.TimedOut),   32'(e_to[c]));
         chk("last",  c, 32'(bus.LastCycles), 32'(e_last[c]));
         if (c == abort_edge) begin
            #2;
            Reset = 1'b0;
            #1;
            chk_reset("async_rst", c);
            break;
         end
      end
   endtask

   initial begin
      int dr[3];
      Reset    = 1'b0;
      bus.Go   = 1'b0;
      bus.Done = 1'b0;

      run(5, '{10, 10, 10}, 0, 1'b0, 60, -1);      // three programs, 10 cycles each
      run(3, '{T, 0, 0}, 0, 1'b0, 40, -1);         // timeout on the first program
      run(2, '{0, 0, 0}, 2, 1'b0, 30, -1);         // Done stuck high
      run(4, '{T - 1, T, 0}, 1, 1'b0, 80, -1);     // Done on last allowed cycle, then timeout
      run(1, '{0, 1, 2}, 1, 1'b1, 200, -1);        // Go held high
      run(2, '{4, 15, 0}, 1, 1'b0, 60, 9);         // abort during program 2 pulse
      run(3, '{4, 15, 0}, 0, 1'b0, 60, 15);        // abort during program 2 run
      run(1, '{0, 0, 0}, 0, 1'b0, 20, -1);         // restart after abort

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 3; k++) dr[k] = int'($urandom_range(0, T + 1));
         run(int'($urandom_range(1, 8)), dr, 1, 1'($urandom_range(0, 1)), 100, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/program_launcher.md
PROGRAM_LAUNCHER -- requirements
Module: program_launcher

Interface
REQ-001 SHALL have parameter NPROG, default 3: number of programs launched per sequence (1..3).
REQ-002 SHALL have parameter START_HI, default 2: cycles Start is held high per launch (>=1).
REQ-003 SHALL have parameter CW, default 16: width of the per-program cycle counter.
REQ-004 SHALL have parameter TIMEOUT, default 16'hFFFF: RUN cycles allowed before abort (1..2^CW-1).
REQ-005 SHALL have port Clk  input  1  single clock; all state changes on posedge Clk.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-low reset (Reset==0 resets immediately, independent of Clk).
REQ-007 SHALL have port Go  input  1  level; sampled high in IDLE begins a launch sequence.
REQ-008 SHALL have port Done  input  1  processor-side done flag for the current program.
REQ-009 SHALL have port Start  output  1  launch pulse to the processor program counter.
REQ-010 SHALL have port ProgIdx  output  2  current program number, 0 = none, 1..NPROG.
REQ-011 SHALL have port Busy  output  1  high in every state except IDLE and FINISH.
REQ-012 SHALL have port Finished  output  1  sticky; sequence ended normally or by timeout.
REQ-013 SHALL have port TimedOut  output  1  sticky; a program exceeded TIMEOUT.
REQ-014 SHALL have port LastCycles  output  CW  RUN cycles used by the most recently completed program.

Function
REQ-015 SHALL implement states IDLE, PULSE, RUN, FINISH as a registered FSM; all outputs registered.
REQ-016 IDLE: Go==1 at a posedge -> PULSE next cycle, ProgIdx<=1, Start<=1, pulse counter<=0; Go==0 -> remain.
REQ-017 PULSE: Start SHALL stay high exactly START_HI consecutive cycles, then drop to 0 as state enters RUN (one clean rising and one falling edge per launch).
REQ-018 PULSE: Done SHALL be ignored (stale Done from the previous program must not complete the new one).
REQ-019 RUN: cycle counter SHALL clear to 0 on entry and increment by 1 each RUN cycle; counter never wraps.
REQ-020 RUN, Done==1: LastCycles<=counter value that cycle; if ProgIdx==NPROG -> FINISH with Finished<=1; else ProgIdx<=ProgIdx+1, Start<=1, -> PULSE.
REQ-021 RUN, Done==0 and counter==TIMEOUT-1: TimedOut<=1, Finished<=1, LastCycles<=TIMEOUT, -> FINISH; no further programs launched.
REQ-022 Done==1 and timeout condition in the same cycle: Done SHALL win (normal completion, TimedOut stays 0).
REQ-023 FINISH: SHALL hold all outputs, Start==0, ignore Go and Done; left only by Reset.
REQ-024 Go held continuously high SHALL launch exactly one sequence (no relaunch without reset).
REQ-025 ProgIdx SHALL never exceed NPROG; Start SHALL never be high outside PULSE.
REQ-026 Launch latency: Start rises the cycle after Go is sampled; next program's Start rises the cycle after Done is sampled in RUN.

Reset
REQ-027 Reset==0 SHALL immediately force state IDLE, Start=0, ProgIdx=0, Busy=0, Finished=0, TimedOut=0, LastCycles=0, all internal counters 0.
REQ-028 Reset asserted mid-PULSE or mid-RUN SHALL abort the sequence with Start dropping asynchronously; after release the block waits in IDLE for Go.
REQ-029 Release of Reset SHALL take effect at the next posedge Clk; no output changes at release itself.

Verification
REQ-030 Defaults, Go pulse at cycle 5, Done asserted 10 RUN cycles after each Start fall -> three Start pulses each 2 cycles wide, ProgIdx 1,2,3, LastCycles=10 each, Finished=1, TimedOut=0.
REQ-031 TIMEOUT=20, Done never asserted -> one Start pulse, TimedOut=1 and Finished=1 exactly 20 cycles after Start falls, ProgIdx stays 1, LastCycles=20.
REQ-032 Done held high throughout -> each program completes on its first RUN cycle, LastCycles=0, no Done accepted during PULSE, Finished after 3 launches.
REQ-033 TIMEOUT=20, Done first asserted on RUN cycle 19 (counter==19) -> normal completion, TimedOut=0, LastCycles=19, ProgIdx advances to 2.
REQ-034 Reset driven low during program 2 RUN, asynchronous to Clk -> Start/ProgIdx/Busy return to 0 without a clock edge; Go after release restarts at ProgIdx=1.
REQ-035 Go held high for 200 cycles with fast Done -> exactly NPROG launches, FINISH holds, no fourth Start pulse.
